// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the single-cycle MIPS datapath: PC, loadable
// instruction memory, 32x32 register file and an IDLE/RUN/HALT run controller.
module fetch_decode_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic        Clk_1b,
  input  logic        Rst_1b,
  input  logic        Start_1b,
  input  logic        Load_1b,
  input  logic [5:0]  LoadAddr_6b,
  input  logic [31:0] LoadData_32b,
  input  logic        RegWrite_1b,
  input  logic [4:0]  WriteReg_5b,
  input  logic [31:0] WriteData_32b,
  input  logic        Branch_1b,
  input  logic        Zero_1b,
  input  logic [31:0] BrAdd_32b,
  output logic [31:0] Instr_32b,
  output logic [5:0]  Opcode_6b,
  output logic [4:0]  Rt_5b,
  output logic [4:0]  Rd_5b,
  output logic [15:0] Imm_16b,
  output logic [31:0] PC_32b,
  output logic [31:0] BusA_32b,
  output logic [31:0] BusB_32b,
  output logic        Valid_1b
);

  localparam int unsigned AddrW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc_plus4;
  logic [31:0]       imem [IMEM_DEPTH];
  logic [31:0]       rf_q [32];
  logic [AddrW-1:0]  fetch_addr;
  logic              is_halt;
  logic              br_taken;
  logic              imem_we;
  logic              rf_we;

  assign pc_plus4   = pc_q + 32'd4;
  // Word address; PC bits above the memory range simply wrap.
  assign fetch_addr = pc_q[AddrW+1:2];
  assign Instr_32b  = imem[fetch_addr];
  assign is_halt    = (Instr_32b == HALT_WORD);
  assign br_taken   = Branch_1b & Zero_1b;

  assign Opcode_6b  = Instr_32b[31:26];
  assign Rt_5b      = Instr_32b[20:16];
  assign Rd_5b      = Instr_32b[15:11];
  assign Imm_16b    = Instr_32b[15:0];
  assign PC_32b     = pc_plus4;
  // RF[0] is never written, so it reads zero without a special case.
  assign BusA_32b   = rf_q[Instr_32b[25:21]];
  assign BusB_32b   = rf_q[Instr_32b[20:16]];
  assign Valid_1b   = (state_q == StRun) && !is_halt;

  assign imem_we    = Load_1b && (state_q != StRun);
  assign rf_we      = RegWrite_1b && (WriteReg_5b != 5'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (Start_1b) state_d = StRun;
      end
      StRun: begin
        if (is_halt) begin
          state_d = StHalt;
        end else begin
          pc_d = br_taken ? BrAdd_32b : pc_plus4;
        end
      end
      StHalt: begin
        if (Start_1b) begin
          state_d = StRun;
          pc_d    = 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_1b or posedge Rst_1b) begin
    if (Rst_1b) begin
      state_q <= StIdle;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge Clk_1b or posedge Rst_1b) begin
    if (Rst_1b) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we) begin
      rf_q[WriteReg_5b] <= WriteData_32b;
    end
  end

  // Program storage survives reset so a loaded program can be rerun.
  always_ff @(posedge Clk_1b) begin
    if (imem_we) imem[LoadAddr_6b[AddrW-1:0]] <= LoadData_32b;
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed self-checking bench for fetch_decode_unit.
module tb_fetch_decode_unit;

  logic        Clk_1b = 1'b0;
  logic        Rst_1b = 1'b0;
  logic        Start_1b = 1'b0;
  logic        Load_1b = 1'b0;
  logic [5:0]  LoadAddr_6b = '0;
  logic [31:0] LoadData_32b = '0;
  logic        RegWrite_1b = 1'b0;
  logic [4:0]  WriteReg_5b = '0;
  logic [31:0] WriteData_32b = '0;
  logic        Branch_1b = 1'b0;
  logic        Zero_1b = 1'b0;
  logic [31:0] BrAdd_32b = '0;
  logic [31:0] Instr_32b;
  logic [5:0]  Opcode_6b;
  logic [4:0]  Rt_5b;
  logic [4:0]  Rd_5b;
  logic [15:0] Imm_16b;
  logic [31:0] PC_32b;
  logic [31:0] BusA_32b;
  logic [31:0] BusB_32b;
  logic        Valid_1b;

  int n_run  = 0;
  int n_fail = 0;

  fetch_decode_unit dut (
    .Clk_1b        (Clk_1b),
    .Rst_1b        (Rst_1b),
    .Start_1b      (Start_1b),
    .Load_1b       (Load_1b),
    .LoadAddr_6b   (LoadAddr_6b),
    .LoadData_32b  (LoadData_32b),
    .RegWrite_1b   (RegWrite_1b),
    .WriteReg_5b   (WriteReg_5b),
    .WriteData_32b (WriteData_32b),
    .Branch_1b     (Branch_1b),
    .Zero_1b       (Zero_1b),
    .BrAdd_32b     (BrAdd_32b),
    .Instr_32b     (Instr_32b),
    .Opcode_6b     (Opcode_6b),
    .Rt_5b         (Rt_5b),
    .Rd_5b         (Rd_5b),
    .Imm_16b       (Imm_16b),
    .PC_32b        (PC_32b),
    .BusA_32b      (BusA_32b),
    .BusB_32b      (BusB_32b),
    .Valid_1b      (Valid_1b)
  );

  always #5 Clk_1b = ~Clk_1b;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge Clk_1b);
    @(negedge Clk_1b);
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    Load_1b = 1'b1; LoadAddr_6b = a; LoadData_32b = d;
    step();
    Load_1b = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    RegWrite_1b = 1'b1; WriteReg_5b = r; WriteData_32b = d;
    step();
    RegWrite_1b = 1'b0;
  endtask

  task automatic start_run();
    Start_1b = 1'b1;
    step();
    Start_1b = 1'b0;
  endtask

  task automatic test_reset();
    #2 Rst_1b = 1'b1;
    #10;
    n_run++; if (PC_32b !== 32'd4) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC_32b, 32'd4); end
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid_1b); end
    n_run++; if (BusA_32b !== 32'd0) begin n_fail++; $display("FAIL reset_busa: got %h want 0", BusA_32b); end
    n_run++; if (BusB_32b !== 32'd0) begin n_fail++; $display("FAIL reset_busb: got %h want 0", BusB_32b); end
    @(negedge Clk_1b);
    Rst_1b = 1'b0;
    step();
    n_run++; if (PC_32b !== 32'd4) begin n_fail++; $display("FAIL idle_pc: got %h want %h", PC_32b, 32'd4); end
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", Valid_1b); end
  endtask

  task automatic test_basic();
    load_word(6'd0, 32'h00221820);
    load_word(6'd1, 32'hFFFFFFFF);
    load_word(6'd2, 32'h00411020);
    load_word(6'd3, 32'h00631820);
    load_word(6'd4, 32'h20010007);
    load_word(6'd5, 32'hFFFFFFFF);
    write_reg(5'd1, 32'd4);
    write_reg(5'd2, 32'd3);
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL loaded_idle_valid: got %b want 0", Valid_1b); end
    n_run++; if (Instr_32b !== 32'h00221820) begin n_fail++; $display("FAIL idle_instr: got %h want %h", Instr_32b, 32'h00221820); end
    start_run();
    n_run++; if (Opcode_6b !== 6'd0) begin n_fail++; $display("FAIL basic_opcode: got %h want 0", Opcode_6b); end
    n_run++; if (BusA_32b !== 32'd4) begin n_fail++; $display("FAIL basic_busa: got %h want 4", BusA_32b); end
    n_run++; if (BusB_32b !== 32'd3) begin n_fail++; $display("FAIL basic_busb: got %h want 3", BusB_32b); end
    n_run++; if (Imm_16b !== 16'h1820) begin n_fail++; $display("FAIL basic_imm: got %h want 1820", Imm_16b); end
    n_run++; if (Rd_5b !== 5'd3) begin n_fail++; $display("FAIL basic_rd: got %0d want 3", Rd_5b); end
    n_run++; if (Rt_5b !== 5'd2) begin n_fail++; $display("FAIL basic_rt: got %0d want 2", Rt_5b); end
    n_run++; if (PC_32b !== 32'd4) begin n_fail++; $display("FAIL basic_pc: got %h want 4", PC_32b); end
    n_run++; if (Valid_1b !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", Valid_1b); end
    step();
    n_run++; if (Instr_32b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL halt_instr: got %h want ffffffff", Instr_32b); end
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b want 0", Valid_1b); end
    n_run++; if (PC_32b !== 32'd8) begin n_fail++; $display("FAIL halt_pc: got %h want 8", PC_32b); end
    step();
    step();
    n_run++; if (PC_32b !== 32'd8) begin n_fail++; $display("FAIL halt_pc_held: got %h want 8", PC_32b); end
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL halt_valid_held: got %b want 0", Valid_1b); end
  endtask

  task automatic test_branch_taken();
    start_run();
    n_run++; if (PC_32b !== 32'd4) begin n_fail++; $display("FAIL restart_pc: got %h want 4", PC_32b); end
    Branch_1b = 1'b1; Zero_1b = 1'b1; BrAdd_32b = 32'h10;
    step();
    Branch_1b = 1'b0; Zero_1b = 1'b0;
    n_run++; if (PC_32b !== 32'h14) begin n_fail++; $display("FAIL br_taken_pc: got %h want 14", PC_32b); end
    n_run++; if (Instr_32b !== 32'h20010007) begin n_fail++; $display("FAIL br_taken_instr: got %h want 20010007", Instr_32b); end
    n_run++; if (Opcode_6b !== 6'h08) begin n_fail++; $display("FAIL br_taken_opcode: got %h want 08", Opcode_6b); end
    n_run++; if (Valid_1b !== 1'b1) begin n_fail++; $display("FAIL br_taken_valid: got %b want 1", Valid_1b); end
    step();
    n_run++; if (PC_32b !== 32'h18) begin n_fail++; $display("FAIL br_seq_pc: got %h want 18", PC_32b); end
    step();
    n_run++; if (PC_32b !== 32'h18) begin n_fail++; $display("FAIL br_halt_pc: got %h want 18", PC_32b); end
  endtask

  task automatic test_branch_not_taken();
    start_run();
    Branch_1b = 1'b1; Zero_1b = 1'b0; BrAdd_32b = 32'h10;
    step();
    Branch_1b = 1'b0;
    n_run++; if (PC_32b !== 32'd8) begin n_fail++; $display("FAIL br_nt_pc: got %h want 8", PC_32b); end
    n_run++; if (Instr_32b !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL br_nt_instr: got %h want ffffffff", Instr_32b); end
    step();
  endtask

  task automatic test_zero_reg();
    write_reg(5'd0, 32'd5);
    start_run();
    Branch_1b = 1'b1; Zero_1b = 1'b1; BrAdd_32b = 32'h10;
    step();
    Branch_1b = 1'b0; Zero_1b = 1'b0;
    n_run++; if (BusA_32b !== 32'd0) begin n_fail++; $display("FAIL r0_busa: got %h want 0", BusA_32b); end
    n_run++; if (BusB_32b !== 32'd4) begin n_fail++; $display("FAIL r0_busb: got %h want 4", BusB_32b); end
    step();
    step();
  endtask

  task automatic test_load_in_run();
    start_run();
    Branch_1b = 1'b1; Zero_1b = 1'b1; BrAdd_32b = 32'h8;
    Load_1b = 1'b1; LoadAddr_6b = 6'd2; LoadData_32b = 32'hDEADBEEF;
    step();
    Branch_1b = 1'b0; Zero_1b = 1'b0; Load_1b = 1'b0;
    n_run++; if (Instr_32b !== 32'h00411020) begin n_fail++; $display("FAIL run_load_ignored: got %h want 00411020", Instr_32b); end
    n_run++; if (PC_32b !== 32'hC) begin n_fail++; $display("FAIL run_load_pc: got %h want c", PC_32b); end
    n_run++; if (Valid_1b !== 1'b1) begin n_fail++; $display("FAIL run_load_valid: got %b want 1", Valid_1b); end
    for (int i = 0; i < 4; i++) step();
    n_run++; if (PC_32b !== 32'h18) begin n_fail++; $display("FAIL run_load_halt_pc: got %h want 18", PC_32b); end
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL run_load_halt_valid: got %b want 0", Valid_1b); end
  endtask

  task automatic test_load_in_halt();
    load_word(6'd2, 32'hDEADBEEF);
    start_run();
    n_run++; if (PC_32b !== 32'd4) begin n_fail++; $display("FAIL halt_load_restart_pc: got %h want 4", PC_32b); end
    n_run++; if (Instr_32b !== 32'h00221820) begin n_fail++; $display("FAIL halt_load_restart_instr: got %h want 00221820", Instr_32b); end
    Branch_1b = 1'b1; Zero_1b = 1'b1; BrAdd_32b = 32'h8;
    step();
    Branch_1b = 1'b0; Zero_1b = 1'b0;
    n_run++; if (Instr_32b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL halt_load_instr: got %h want deadbeef", Instr_32b); end
    n_run++; if (Opcode_6b !== 6'h37) begin n_fail++; $display("FAIL halt_load_opcode: got %h want 37", Opcode_6b); end
    step();
    n_run++; if (PC_32b !== 32'h10) begin n_fail++; $display("FAIL pre_reset_pc: got %h want 10", PC_32b); end
    n_run++; if (Valid_1b !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", Valid_1b); end
  endtask

  task automatic test_reset_mid_run();
    #1 Rst_1b = 1'b1;
    #1;
    n_run++; if (PC_32b !== 32'd4) begin n_fail++; $display("FAIL mid_reset_pc: got %h want 4", PC_32b); end
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", Valid_1b); end
    n_run++; if (Instr_32b !== 32'h00221820) begin n_fail++; $display("FAIL mid_reset_imem: got %h want 00221820", Instr_32b); end
    n_run++; if (BusA_32b !== 32'd0) begin n_fail++; $display("FAIL mid_reset_rf1: got %h want 0", BusA_32b); end
    n_run++; if (BusB_32b !== 32'd0) begin n_fail++; $display("FAIL mid_reset_rf2: got %h want 0", BusB_32b); end
    @(negedge Clk_1b);
    Rst_1b = 1'b0;
    step();
    n_run++; if (Valid_1b !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", Valid_1b); end
    start_run();
    n_run++; if (Valid_1b !== 1'b1) begin n_fail++; $display("FAIL post_reset_start: got %b want 1", Valid_1b); end
    n_run++; if (BusA_32b !== 32'd0) begin n_fail++; $display("FAIL post_reset_busa: got %h want 0", BusA_32b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch_taken();
    test_branch_not_taken();
    test_zero_reg();
    test_load_in_run();
    test_load_in_halt();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Upstream neighbour of the execution control unit in the single-cycle MIPS datapath. Holds the program counter, a loadable instruction memory and the 32x32 register file, and presents the current instruction's Opcode_6b, PC (as PC+4), BusA_32b, BusB_32b and Imm_16b to the execution stage. Next-PC selection uses the branch decision returned from the execution stage. A small run-control FSM (IDLE/RUN/HALT) lets the bench load a program, start it and detect completion.

## Interface
- IMEM_DEPTH, 64: instruction memory words; address = PC[7:2] (log2 depth bits)
- HALT_WORD, 32'hFFFFFFFF: sentinel instruction that stops execution
- Clk_1b  in  1  single clock, all state updates on rising edge
- Rst_1b  in  1  reset, asynchronous, active-high
- Start_1b  in  1  start/restart request, sampled at rising edge
- Load_1b  in  1  instruction-memory write enable
- LoadAddr_6b  in  6  instruction-memory word address
- LoadData_32b  in  32  instruction word to write
- RegWrite_1b  in  1  register-file write enable (from writeback)
- WriteReg_5b  in  5  destination register number
- WriteData_32b  in  32  write data
- Branch_1b  in  1  Signals_9b[5] from execution stage
- Zero_1b  in  1  ALU zero flag from execution stage
- BrAdd_32b  in  32  branch target from execution stage
- Instr_32b  out  32  current instruction word
- Opcode_6b  out  6  Instr_32b[31:26]
- Rt_5b  out  5  Instr_32b[20:16]
- Rd_5b  out  5  Instr_32b[15:11]
- Imm_16b  out  16  Instr_32b[15:0] (funct in [5:0])
- PC_32b  out  32  PC+4 of current instruction (feeds branch adder)
- BusA_32b  out  32  RF[Instr[25:21]]
- BusB_32b  out  32  RF[Instr[20:16]]
- Valid_1b  out  1  state==RUN and Instr_32b != HALT_WORD

## Operation
- FSM states: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: Start_1b -> RUN, PC unchanged.
- RUN: every edge, PC <= (Branch_1b & Zero_1b) ? BrAdd_32b : PC+4. If Instr_32b == HALT_WORD: -> HALT, PC held. Start_1b ignored.
- HALT: PC held. Start_1b -> RUN with PC <= 0.
- Instruction memory: write at edge when Load_1b=1 and state is IDLE or HALT; Load_1b ignored in RUN. Read combinational at PC[7:2]; PC bits above wrap modulo IMEM_DEPTH. Not cleared by reset.
- Register file: write at edge when RegWrite_1b=1, any state. WriteReg_5b==0 discarded; RF[0] always reads 0. Reads combinational, no bypass: a write becomes visible after the edge.
- All arithmetic 32-bit unsigned, PC+4 wraps at 2^32. BrAdd_32b used verbatim (no alignment check; low bits ignored by addressing).
- Simultaneous Load and Start in IDLE/HALT: both take effect at the same edge; first RUN fetch sees the new word.
- Downstream must qualify RegWrite/MemWrite with Valid_1b; the execution control unit has no decode for opcode 6'b111111.

## Timing
- Reset (async, immediate): PC=0, state=IDLE, RF[0..31]=0, Valid_1b=0; Instr_32b/Opcode_6b/Imm_16b/Rt_5b/Rd_5b reflect imem[0]; BusA_32b/BusB_32b=0; PC_32b=4.
- All outputs combinational from PC, imem and RF; valid same cycle as PC update.
- Start at edge k: Valid_1b high after edge k (unless imem[PC] is HALT_WORD).
- Branch taken in cycle n: instruction at BrAdd_32b presented in cycle n+1.
- HALT_WORD presented in cycle n: Valid_1b low in cycle n; state HALT after edge n.
- Reset asserted mid-RUN: immediate return to IDLE, PC=0, RF cleared; imem contents retained.

## Test plan
- Reset: assert Rst_1b -> PC_32b=4, Valid_1b=0, BusA_32b=BusB_32b=0, state IDLE.
- Load imem[0]=32'h00221820, imem[1]=HALT_WORD; write RF[1]=4, RF[2]=3; Start -> Opcode_6b=0, BusA_32b=4, BusB_32b=3, Imm_16b=16'h1820, Rd_5b=3, PC_32b=4, Valid_1b=1; next cycle Instr_32b=32'hFFFFFFFF, Valid_1b=0, then HALT with PC_32b held at 8.
- Branch: in RUN at PC 0 drive Branch_1b=1, Zero_1b=1, BrAdd_32b=32'h10 -> next cycle PC_32b=32'h14, Instr_32b=imem[4]; with Zero_1b=0 -> PC_32b=8.
- $0: RegWrite_1b=1, WriteReg_5b=0, WriteData_32b=5; instruction with rs=0 -> BusA_32b=0.
- Load in RUN: Load_1b=1, LoadAddr_6b=2, LoadData_32b=32'hDEADBEEF -> imem[2] unchanged on later fetch; in HALT same load -> takes effect; Start -> PC restarts at 0.
- Reset mid-RUN at PC 32'h0C -> immediately PC_32b=4, Valid_1b=0, RF[1] reads 0, imem[0] still 32'h00221820.
